seq_det_ctrl: RTL and testbench

Sequencing controller for the serial pattern detector. It accepts parallel words over a valid/ready handshake and serializes them MSB-first into a programmable pattern-match core. It counts matches and raises a sticky interrupt when a programmed match threshold is reached. It sits between the bus-side word source and the bit-serial detector, and owns the detector's configuration and history.

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_det_core.sv | 60 ++++++
 rtl/seq_det_ctrl.sv | 133 +++++++++++++
 tb/tb_seq_det_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared FSM type and default widths for the serial pattern detector.
package seq_det_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_t;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefPatW  = 4;
    localparam int unsigned DefCntW  = 8;

endpackage

// File: rtl/seq_det_core.sv
// Bit-serial pattern-match core: history shift register, fill counter, registered match.
// Build option SEQDET_NONOVERLAP_EN: clear the fill counter on a match (non-overlapping).
module seq_det_core
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = DefPatW
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    output logic             match
);

    localparam int unsigned      FillW    = $clog2(PAT_W + 1);
    localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FillW-1:0] fill_q, fill_d;
    logic             match_q, match_d;

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bit_valid) begin
            hist_d = {hist_q[PAT_W-2:0], bit_in};
            if (fill_q != FillFull) begin
                fill_d = fill_q + FillW'(1);
            end
            match_d = (fill_d == FillFull) && (hist_d == pattern);
`ifdef SEQDET_NONOVERLAP_EN
            if (match_d) begin
                fill_d = '0;
            end
`else
`endif
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// Sequencing controller: word handshake, MSB-first serializer, match counter and sticky irq.
// Overlap behaviour of the core is selected by SEQDET_NONOVERLAP_EN.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned PAT_W  = DefPatW,
    parameter int unsigned CNT_W  = DefCntW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [CNT_W-1:0]  cfg_threshold,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              irq,
    input  logic              irq_clr
);

    localparam int unsigned    BcW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BcW-1:0] LastBit = BcW'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BcW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PAT_W-1:0]  pattern_q;
    logic [CNT_W-1:0]  thresh_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              irq_q, irq_d;

    logic last_bit;
    logic accept;
    logic cfg_ok;
    logic core_match;

    assign last_bit = (state_q == StShift) && (bit_cnt_q == LastBit);
    assign in_ready = (state_q == StIdle) || last_bit;
    assign accept   = in_valid && in_ready;
    assign cfg_ok   = cfg_we && (state_q == StIdle);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + BcW'(1);
                if (last_bit) begin
                    // Reload on the last bit keeps back-to-back words bubble-free.
                    if (accept) begin
                        shreg_d   = in_data;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        irq_d   = irq_q;
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        // Set beats clear; a saturated counter never re-triggers.
        if (core_match && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
            if ((thresh_q != '0) && (count_d == thresh_q)) begin
                irq_d = 1'b1;
            end
        end
        if (cfg_ok) begin
            count_d = '0;
            irq_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            pattern_q <= '0;
            thresh_q  <= '0;
            count_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            count_q   <= count_d;
            irq_q     <= irq_d;
            if (cfg_ok) begin
                pattern_q <= cfg_pattern;
                thresh_q  <= cfg_threshold;
            end
        end
    end

    seq_det_core #(
        .PAT_W(PAT_W)
    ) u_core (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (cfg_ok),
        .bit_valid(state_q == StShift),
        .bit_in   (shreg_q[DATA_W-1]),
        .pattern  (pattern_q),
        .match    (core_match)
    );

    assign busy        = (state_q == StShift);
    assign match_pulse = core_match;
    assign match_count = count_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus random traffic vs a bit-queue model.
module tb_seq_det_ctrl;

    localparam int DATA_W = 8;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 8;
    localparam int CntMax = (1 << CNT_W) - 1;
`ifdef SEQDET_NONOVERLAP_EN
    localparam bit NonOv = 1'b1;
`else
    localparam bit NonOv = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              cfg_we = 1'b0;
    logic [PAT_W-1:0]  cfg_pattern = '0;
    logic [CNT_W-1:0]  cfg_threshold = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              irq_clr = 1'b0;
    logic              in_ready;
    logic              busy;
    logic              match_pulse;
    logic [CNT_W-1:0]  match_count;
    logic              irq;

    int n_cmp = 0;
    int n_err = 0;

    seq_det_ctrl #(
        .DATA_W(DATA_W),
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cfg_we       (cfg_we),
        .cfg_pattern  (cfg_pattern),
        .cfg_threshold(cfg_threshold),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .busy         (busy),
        .match_pulse  (match_pulse),
        .match_count  (match_count),
        .irq          (irq),
        .irq_clr      (irq_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending bits as a queue, history as an integer, run = bits since clear/match.
    bit m_pend[$];
    int m_hist, m_run, m_pat, m_thr, m_cnt;
    bit m_irq, m_pulse;

    always @(posedge clk) begin
        bit present, b, ready, new_pulse;
        if (rstn) begin
            m_pend.delete();
            m_hist = 0; m_run = 0; m_pat = 0; m_thr = 0; m_cnt = 0;
            m_irq = 1'b0; m_pulse = 1'b0;
        end else begin
            present   = m_pend.size() > 0;
            b         = present ? m_pend[0] : 1'b0;
            ready     = m_pend.size() <= 1;
            new_pulse = 1'b0;
            if (cfg_we && !present) begin
                m_pat = int'(cfg_pattern); m_thr = int'(cfg_threshold);
                m_hist = 0; m_run = 0; m_cnt = 0; m_irq = 1'b0;
            end else begin
                if (present) begin
                    m_hist = ((m_hist << 1) | int'(b)) & ((1 << PAT_W) - 1);
                    if (m_run < PAT_W) m_run++;
                    if (m_run == PAT_W && m_hist == m_pat) begin
                        new_pulse = 1'b1;
                        if (NonOv) m_run = 0;
                    end
                end
                if (irq_clr) m_irq = 1'b0;
                if (m_pulse && m_cnt < CntMax) begin
                    m_cnt++;
                    if (m_thr != 0 && m_cnt == m_thr) m_irq = 1'b1;
                end
            end
            if (present) void'(m_pend.pop_front());
            if (in_valid && ready) begin
                for (int i = DATA_W - 1; i >= 0; i--) m_pend.push_back(in_data[i]);
            end
            m_pulse = new_pulse;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            check("rst_ready", 32'(in_ready), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_pulse", 32'(match_pulse), 32'd0);
            check("rst_count", 32'(match_count), 32'd0);
            check("rst_irq", 32'(irq), 32'd0);
        end else begin
            check("m_ready", 32'(in_ready), 32'(m_pend.size() <= 1));
            check("m_busy", 32'(busy), 32'(m_pend.size() > 0));
            check("m_pulse", 32'(match_pulse), 32'(m_pulse));
            check("m_count", 32'(match_count), 32'(m_cnt));
            check("m_irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            tick();
            t++;
        end
        if (busy) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic configure(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] thr);
        wait_idle();
        cfg_we = 1'b1; cfg_pattern = pat; cfg_threshold = thr;
        tick();
        cfg_we = 1'b0;
    endtask

    // Returns in the cycle after the accepting edge, i.e. while the MSB is presented.
    task automatic send_word(input logic [DATA_W-1:0] w);
        int t = 0;
        in_valid = 1'b1; in_data = w;
        while (!in_ready && t < 100) begin
            tick();
            t++;
        end
        if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        tick(2);
        rstn = 1'b0;
        tick();
        check("reset_count", 32'(match_count), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);

        // 1011 against 0xB6, threshold 2
        configure(4'b1011, 8'd2);
        send_word(8'hB6);
        tick(4);
        check("b6_pulse_t5", 32'(match_pulse), 32'd1);
        tick(1);
        check("b6_count_t6", 32'(match_count), 32'd1);
        tick(2);
        check("b6_pulse_t8", 32'(match_pulse), NonOv ? 32'd0 : 32'd1);
        tick(1);
        check("b6_count_t9", 32'(match_count), NonOv ? 32'd1 : 32'd2);
        check("b6_irq", 32'(irq), NonOv ? 32'd0 : 32'd1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("irq_cleared", 32'(irq), 32'd0);

        // irq_clr coinciding with the threshold hit
        configure(4'b1011, 8'd1);
        send_word(8'hB6);
        tick(4);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("set_wins_irq", 32'(irq), 32'd1);
        check("set_wins_count", 32'(match_count), 32'd1);

        // Back-to-back 0x01, 0x60: one match across the boundary
        configure(4'b1011, 8'd0);
        in_valid = 1'b1; in_data = 8'h01;
        tick();
        in_data = 8'h60;
        tick(7);
        check("b2b_ready_last", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("b2b_no_bubble", 32'(busy), 32'd1);
        tick(3);
        check("b2b_pulse_t12", 32'(match_pulse), 32'd1);
        wait_idle();
        tick(2);
        check("b2b_count", 32'(match_count), 32'd1);

        // cfg_we while shifting is ignored
        send_word(8'h00);
        tick(2);
        cfg_we = 1'b1; cfg_pattern = 4'b0000; cfg_threshold = 8'd1;
        tick();
        cfg_we = 1'b0;
        wait_idle();
        tick(2);
        check("busy_cfg_count", 32'(match_count), 32'd1);
        check("busy_cfg_irq", 32'(irq), 32'd0);

        // cfg_we in idle clears history: trailing 101 must not complete with a leading 1
        send_word(8'h05);
        wait_idle();
        configure(4'b1011, 8'd0);
        check("cfg_clr_count", 32'(match_count), 32'd0);
        send_word(8'hC0);
        wait_idle();
        tick(2);
        check("cfg_clr_hist", 32'(match_count), 32'd0);

        // Reset mid-word
        configure(4'b1011, 8'd0);
        send_word(8'hB6);
        tick(2);
        rstn = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        tick(2);
        rstn = 1'b0;
        tick(3);
        check("postrst_pulse", 32'(match_pulse), 32'd0);
        check("postrst_count", 32'(match_count), 32'd0);
        send_word(8'h00);
        tick(3);
        check("postrst_no_early", 32'(match_pulse), 32'd0);
        tick(1);
        check("postrst_first", 32'(match_pulse), 32'd1);
        wait_idle();
        tick(2);
        check("postrst_total", 32'(match_count), NonOv ? 32'd2 : 32'd5);

        // Saturation: 34 words of 0xFF with pattern 1111
        configure(4'b1111, 8'd0);
        in_valid = 1'b1; in_data = 8'hFF;
        tick(34 * DATA_W);
        in_valid = 1'b0;
        wait_idle();
        tick(2);
        check("sat_count", 32'(match_count), NonOv ? 32'd68 : 32'd255);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            in_data       = DATA_W'($urandom);
            cfg_we        = ($urandom_range(0, 29) == 0);
            cfg_pattern   = PAT_W'($urandom);
            cfg_threshold = CNT_W'($urandom_range(0, 5));
            irq_clr       = ($urandom_range(0, 19) == 0);
            rstn          = ($urandom_range(0, 299) == 0);
            tick();
        end
        in_valid = 1'b0; cfg_we = 1'b0; irq_clr = 1'b0; rstn = 1'b0;
        tick(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
